// File: rtl/sram_pkg.sv
// Shared types for the banked byte-lane SRAM controller.
// Latency: none (types and a pure function only).
// Backpressure: not applicable.
package sram_pkg;

  typedef enum logic [1:0] {
    PWR_ACTIVE = 2'b00,
    PWR_SLEEP  = 2'b01,
    PWR_WAKE   = 2'b10
  } pwr_state_e;

  // Bank field is sized for the largest bank count we expect to build;
  // narrower configurations zero-extend into it.
  localparam int RD_BANK_W = 8;

  typedef struct packed {
    logic                 valid;
    logic [RD_BANK_W-1:0] bank;
  } rd_pipe_t;

  // Flat position of (bank, lane) in the sram_cs / sram_rdata ordering.
  function automatic int lane_idx(input int bank, input int lane, input int lanes);
    return bank * lanes + lane;
  endfunction

endpackage

// File: rtl/sram_pwr_fsm.sv
// Idle-timeout sleep / wake power sequencer for the SRAM macros.
// Latency: SLEEP entered the cycle after the idle limit; ACTIVE after WAKE_CYCLES in WAKE.
// Backpressure: ready_gate is low in SLEEP, WAKE and on the idle-limit cycle itself.
module sram_pwr_fsm
  import sram_pkg::*;
#(
  parameter int IDLE_TIMEOUT = 16,
  parameter int WAKE_CYCLES  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       accept,
  input  logic       busy,
  input  logic       req_valid,
  output logic       ready_gate,
  output logic       sram_sleep,
  output logic [1:0] pwr_state
);

  localparam logic [1:0] ST_ACTIVE = PWR_ACTIVE;
  localparam logic [1:0] ST_SLEEP  = PWR_SLEEP;
  localparam logic [1:0] ST_WAKE   = PWR_WAKE;

  localparam int IW = (IDLE_TIMEOUT < 1) ? 1 : $clog2(IDLE_TIMEOUT + 1);
  localparam int WW = (WAKE_CYCLES < 2) ? 1 : $clog2(WAKE_CYCLES);

  logic [1:0]    state;
  logic [IW-1:0] idle_cnt;
  logic [WW-1:0] wake_cnt;
  logic          at_limit;

  // Idle limit reached: blocks accepts this cycle so nothing races the sleep entry.
  always_comb begin
    at_limit = 1'b0;
    if (IDLE_TIMEOUT != 0)
      at_limit = (idle_cnt == IW'(IDLE_TIMEOUT));
  end

  assign ready_gate = (state == ST_ACTIVE) && !at_limit;
  assign sram_sleep = (state == ST_SLEEP);
  assign pwr_state  = state;

  // State register plus idle and wake counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_ACTIVE;
      idle_cnt <= '0;
      wake_cnt <= '0;
    end else begin
      case (state)
        ST_ACTIVE: begin
          if (at_limit) begin
            state    <= ST_SLEEP;
            idle_cnt <= '0;
          end else if (accept) begin
            idle_cnt <= '0;
          end else if (!busy && (IDLE_TIMEOUT != 0)) begin
            idle_cnt <= idle_cnt + IW'(1);
          end
        end
        ST_SLEEP: begin
          wake_cnt <= '0;
          if (req_valid)
            state <= ST_WAKE;
        end
        ST_WAKE: begin
          if (wake_cnt == WW'(WAKE_CYCLES - 1)) begin
            state    <= ST_ACTIVE;
            idle_cnt <= '0;
          end else begin
            wake_cnt <= wake_cnt + WW'(1);
          end
        end
        default: state <= ST_ACTIVE;
      endcase
    end
  end

endmodule

// File: rtl/sram_bank_ctrl.sv
// Word-wide request port onto NUM_BANKS x LANES byte-wide single-port SRAM macros.
// Latency: macro strobes in T+1 after accept; read response (rsp_valid) in T+3, fully pipelined.
// Backpressure: req_ready only drops for power management; responses cannot be stalled.
module sram_bank_ctrl
  import sram_pkg::*;
#(
  parameter  int SRAM_DATA_WIDTH = 8,
  parameter  int SRAM_ADDR_WIDTH = 13,
  parameter  int DATA_WIDTH      = 32,
  parameter  int NUM_BANKS       = 2,
  parameter  int IDLE_TIMEOUT    = 16,
  parameter  int WAKE_CYCLES     = 2,
  localparam int LANES           = DATA_WIDTH / SRAM_DATA_WIDTH,
  localparam int BANK_BITS       = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
  input  logic                                       hclk,
  input  logic                                       hreset,
  input  logic                                       req_valid,
  output logic                                       req_ready,
  input  logic                                       req_we,
  input  logic [SRAM_ADDR_WIDTH+BANK_BITS-1:0]       req_addr,
  input  logic [DATA_WIDTH-1:0]                      req_wdata,
  input  logic [LANES-1:0]                           req_be,
  output logic                                       rsp_valid,
  output logic [DATA_WIDTH-1:0]                      rsp_rdata,
  output logic                                       sram_we,
  output logic [SRAM_ADDR_WIDTH-1:0]                 sram_addr,
  output logic [DATA_WIDTH-1:0]                      sram_wdata,
  output logic [NUM_BANKS*LANES-1:0]                 sram_cs,
  input  logic [NUM_BANKS*LANES*SRAM_DATA_WIDTH-1:0] sram_rdata,
  output logic                                       sram_sleep,
  output logic [1:0]                                 pwr_state
);

  logic                       accept;
  logic                       busy;
  logic [BANK_BITS-1:0]       req_bank;
  logic [NUM_BANKS*LANES-1:0] cs_nxt;
  logic [DATA_WIDTH-1:0]      bank_rdata;
  rd_pipe_t                   rd_s1;
  rd_pipe_t                   rd_s2;

  assign accept   = req_valid && req_ready;
  assign req_bank = req_addr[SRAM_ADDR_WIDTH +: BANK_BITS];
  assign busy     = rd_s1.valid || rd_s2.valid;

  sram_pwr_fsm #(
    .IDLE_TIMEOUT (IDLE_TIMEOUT),
    .WAKE_CYCLES  (WAKE_CYCLES)
  ) u_pwr (
    .clk        (hclk),
    .rst        (hreset),
    .accept     (accept),
    .busy       (busy),
    .req_valid  (req_valid),
    .ready_gate (req_ready),
    .sram_sleep (sram_sleep),
    .pwr_state  (pwr_state)
  );

  // Chip selects for the addressed bank: writes follow the byte strobes, reads take every lane.
  always_comb begin
    cs_nxt = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      for (int i = 0; i < LANES; i++) begin
        if (req_bank == BANK_BITS'(b))
          cs_nxt[lane_idx(b, i, LANES)] = req_we ? req_be[i] : 1'b1;
      end
    end
  end

  // Macro interface: strobes live for one cycle, address and data hold between accesses.
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      sram_cs    <= '0;
      sram_we    <= 1'b0;
      sram_addr  <= '0;
      sram_wdata <= '0;
    end else begin
      sram_cs <= accept ? cs_nxt : '0;
      sram_we <= accept && req_we;
      if (accept) begin
        sram_addr  <= req_addr[SRAM_ADDR_WIDTH-1:0];
        sram_wdata <= req_wdata;
      end
    end
  end

  // Read tag pipeline: carries the bank index alongside the macro access.
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      rd_s1 <= '0;
      rd_s2 <= '0;
    end else begin
      rd_s1.valid <= accept && !req_we;
      rd_s1.bank  <= RD_BANK_W'(req_bank);
      rd_s2       <= rd_s1;
    end
  end

  // Pick the tagged bank's lanes out of the macro outputs.
  always_comb begin
    bank_rdata = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (rd_s2.bank == RD_BANK_W'(b))
        bank_rdata = sram_rdata[b*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Response register: one pulse per read, data held until the next read returns.
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= rd_s2.valid;
      if (rd_s2.valid)
        rsp_rdata <= bank_rdata;
    end
  end

endmodule
